// File: rtl/bias_ctrl_seq.sv
// rtl/bias_ctrl_seq.sv - power-up sequencer, trim shadow and VBIAS gate for the EG1D80V bandgap/bias cell
// Walks OFF -> STARTUP -> SETTLE -> WAIT_VALID -> READY and latches FAULT until the request drops.
module bias_ctrl_seq #(
  parameter int unsigned STARTUP_CYCLES = 64,
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13,
  parameter logic [3:0]  TRIM_BIAS_RST  = 4'h8,
  parameter logic [4:0]  TRIM_CURV_RST  = 5'h10,
  parameter logic [4:0]  TRIM_VBG_RST   = 5'h10
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       REQ_I,
  input  logic       VBIAS_REQ_I,
  input  logic       TRIM_LOAD_I,
  input  logic [3:0] TRIM_BIAS_CFG_I,
  input  logic [4:0] TRIM_CURV_CFG_I,
  input  logic [4:0] TRIM_VBG_CFG_I,
  input  logic       BG_VALID_N_I,
  output logic       EN_O,
  output logic       EN_VBIAS_O,
  output logic       BG_STARTUP_O,
  output logic [3:0] TRIM_BIAS_O,
  output logic [4:0] TRIM_CURV_O,
  output logic [4:0] TRIM_VBG_O,
  output logic       READY_O,
  output logic       FAULT_O,
  output logic [2:0] STATE_O
);

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_STARTUP = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_READY   = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [2:0]       state;
  logic [2:0]       stateNext;
  logic [CNT_W-1:0] cnt;
  logic             trimLoad;
  logic             vldMeta;
  logic             vldNS;
  logic             vldNSPrev;

  // The valid flag comes straight from the analog cell, so it is resynchronised
  // and also delayed one more cycle to filter single-cycle glitches in READY.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      vldMeta   <= 1'b1;
      vldNS     <= 1'b1;
      vldNSPrev <= 1'b1;
    end else begin
      vldMeta   <= BG_VALID_N_I;
      vldNS     <= vldMeta;
      vldNSPrev <= vldNS;
    end
  end

  always_comb begin
    stateNext = state;
    trimLoad  = 1'b0;
    if (!REQ_I) begin
      stateNext = S_OFF;
      trimLoad  = TRIM_LOAD_I && ((state == S_OFF) || (state == S_READY));
    end else begin
      case (state)
        S_OFF: begin
          stateNext = S_STARTUP;
          trimLoad  = TRIM_LOAD_I;
        end
        S_STARTUP: if (cnt == STARTUP_LAST) stateNext = S_SETTLE;
        S_SETTLE:  if (cnt == SETTLE_LAST) stateNext = S_WAIT;
        S_WAIT: begin
          if (!vldNS) stateNext = S_READY;
          else if (cnt == TIMEOUT_LAST) stateNext = S_FAULT;
        end
        S_READY: begin
          // New trims move the reference, so the bandgap has to re-qualify.
          if (TRIM_LOAD_I) begin
            stateNext = S_SETTLE;
            trimLoad  = 1'b1;
          end else if (vldNS && vldNSPrev) begin
            stateNext = S_FAULT;
          end
        end
        S_FAULT: stateNext = S_FAULT;
        default: stateNext = S_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the entry edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state        <= S_OFF;
      cnt          <= '0;
      EN_O         <= 1'b0;
      EN_VBIAS_O   <= 1'b0;
      BG_STARTUP_O <= 1'b0;
      READY_O      <= 1'b0;
      FAULT_O      <= 1'b0;
      TRIM_BIAS_O  <= TRIM_BIAS_RST;
      TRIM_CURV_O  <= TRIM_CURV_RST;
      TRIM_VBG_O   <= TRIM_VBG_RST;
    end else begin
      state <= stateNext;
      if (stateNext != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      EN_O         <= (stateNext == S_STARTUP) || (stateNext == S_SETTLE) ||
                      (stateNext == S_WAIT) || (stateNext == S_READY);
      EN_VBIAS_O   <= (stateNext == S_READY) && VBIAS_REQ_I;
      BG_STARTUP_O <= (stateNext == S_STARTUP);
      READY_O      <= (stateNext == S_READY);
      FAULT_O      <= (stateNext == S_FAULT);
      if (trimLoad) begin
        TRIM_BIAS_O <= TRIM_BIAS_CFG_I;
        TRIM_CURV_O <= TRIM_CURV_CFG_I;
        TRIM_VBG_O  <= TRIM_VBG_CFG_I;
      end
    end
  end

  assign STATE_O = state;

endmodule

// File: tb/tb_bias_ctrl_seq.sv
// tb/tb_bias_ctrl_seq.sv - directed and random checks of bias_ctrl_seq against a phase/age reference model
module tb_bias_ctrl_seq;

  localparam int STARTUP_CYCLES = 64;
  localparam int SETTLE_CYCLES  = 256;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int P_OFF = 0, P_STARTUP = 1, P_SETTLE = 2, P_WAIT = 3, P_READY = 4, P_FAULT = 5;
  localparam logic [21:0] RST_VEC = {3'd0, 5'b00000, 4'h8, 5'h10, 5'h10};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       vbiasReq = 1'b0;
  logic       trimLoad = 1'b0;
  logic       bgValidN = 1'b1;
  logic [3:0] cfgBias = '0;
  logic [4:0] cfgCurv = '0;
  logic [4:0] cfgVbg = '0;

  logic       en, enVbias, bgStartup, ready, fault;
  logic [3:0] trimBias;
  logic [4:0] trimCurv, trimVbg;
  logic [2:0] state;

  int nChecks = 0;
  int nErrors = 0;
  int steps;
  int startupHighs;

  int         mPhase;
  int         mAge;
  logic       mEnVbias;
  logic [3:0] mBias;
  logic [4:0] mCurv, mVbg;
  logic       hist[$];

  always #5 clk = ~clk;

  bias_ctrl_seq dut (
    .CLK_I(clk), .RST_I(rst), .REQ_I(req), .VBIAS_REQ_I(vbiasReq), .TRIM_LOAD_I(trimLoad),
    .TRIM_BIAS_CFG_I(cfgBias), .TRIM_CURV_CFG_I(cfgCurv), .TRIM_VBG_CFG_I(cfgVbg),
    .BG_VALID_N_I(bgValidN), .EN_O(en), .EN_VBIAS_O(enVbias), .BG_STARTUP_O(bgStartup),
    .TRIM_BIAS_O(trimBias), .TRIM_CURV_O(trimCurv), .TRIM_VBG_O(trimVbg),
    .READY_O(ready), .FAULT_O(fault), .STATE_O(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] obsVec();
    return {state, en, enVbias, bgStartup, ready, fault, trimBias, trimCurv, trimVbg};
  endfunction

  function automatic logic [21:0] expVec();
    return {3'(mPhase), (mPhase >= P_STARTUP && mPhase <= P_READY), mEnVbias,
            (mPhase == P_STARTUP), (mPhase == P_READY), (mPhase == P_FAULT), mBias, mCurv, mVbg};
  endfunction

  task automatic modelReset();
    mPhase = P_OFF;
    mAge = 0;
    mEnVbias = 1'b0;
    mBias = 4'h8;
    mCurv = 5'h10;
    mVbg = 5'h10;
    hist = {1'b1, 1'b1, 1'b1};
  endtask

  // One clock: the model decides the next phase from the present inputs, then DUT is compared after the edge.
  task automatic step();
    int   nxt;
    int   n;
    logic load;
    logic vNs, vPrev;
    n = hist.size();
    vNs = hist[n-2];
    vPrev = hist[n-3];
    nxt = mPhase;
    load = 1'b0;
    if (!req) begin
      nxt = P_OFF;
      load = trimLoad && (mPhase == P_OFF || mPhase == P_READY);
    end else begin
      case (mPhase)
        P_OFF: begin nxt = P_STARTUP; load = trimLoad; end
        P_STARTUP: if (mAge + 1 >= STARTUP_CYCLES) nxt = P_SETTLE;
        P_SETTLE: if (mAge + 1 >= SETTLE_CYCLES) nxt = P_WAIT;
        P_WAIT: begin
          if (!vNs) nxt = P_READY;
          else if (mAge + 1 >= TIMEOUT_CYCLES) nxt = P_FAULT;
        end
        P_READY: begin
          if (trimLoad) begin nxt = P_SETTLE; load = 1'b1; end
          else if (vNs && vPrev) nxt = P_FAULT;
        end
        default: ;
      endcase
    end
    mAge = (nxt == mPhase) ? mAge + 1 : 0;
    mPhase = nxt;
    mEnVbias = (nxt == P_READY) && vbiasReq;
    if (load) begin
      mBias = cfgBias;
      mCurv = cfgCurv;
      mVbg = cfgVbg;
    end
    hist.push_back(bgValidN);
    if (hist.size() > 4) void'(hist.pop_front());
    @(posedge clk);
    #1;
    if (bgStartup) startupHighs++;
    chk("cycle_outputs", 32'(obsVec()), 32'(expVec()));
  endtask

  task automatic runUntil(input logic [2:0] target, input int budget, input string tag, output int n);
    n = 0;
    while (state !== target && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(state), 32'(target));
  endtask

  initial begin
    modelReset();
    #12;
    chk("reset_outputs", 32'(obsVec()), 32'(RST_VEC));
    rst = 1'b0;

    // Power-up with valid arriving right after WAIT_VALID entry
    req = 1'b1;
    startupHighs = 0;
    step();
    chk("t1_en_cycle1", 32'(en), 32'd1);
    chk("t1_state_startup", 32'(state), 32'd1);
    runUntil(3'd2, 200, "t1_reach_settle", steps);
    chk("t1_startup_len", 32'(steps), 32'd64);
    chk("t1_startup_high_cycles", 32'(startupHighs), 32'd64);
    runUntil(3'd3, 400, "t1_reach_wait", steps);
    chk("t1_settle_len", 32'(steps), 32'd256);
    bgValidN = 1'b0;
    runUntil(3'd4, 10, "t1_reach_ready", steps);
    chk("t1_ready_delay", 32'(steps), 32'd3);
    chk("t1_ready_o", 32'(ready), 32'd1);

    // VBIAS gating and glitch filter in READY
    vbiasReq = 1'b1;
    step();
    chk("t3_vbias_on", 32'(enVbias), 32'd1);
    bgValidN = 1'b1;
    step();
    bgValidN = 1'b0;
    repeat (6) step();
    chk("t3_glitch_state", 32'(state), 32'd4);
    chk("t3_glitch_vbias", 32'(enVbias), 32'd1);
    bgValidN = 1'b1;
    repeat (3) step();
    bgValidN = 1'b0;
    runUntil(3'd5, 6, "t3_reach_fault", steps);
    chk("t3_fault_vbias", 32'(enVbias), 32'd0);
    chk("t3_fault_o", 32'(fault), 32'd1);

    // Timeout in WAIT_VALID and fault clear
    req = 1'b0;
    vbiasReq = 1'b0;
    step();
    chk("t2_clear_state", 32'(state), 32'd0);
    chk("t2_clear_fault", 32'(fault), 32'd0);
    req = 1'b1;
    bgValidN = 1'b1;
    runUntil(3'd3, 400, "t2_reach_wait", steps);
    runUntil(3'd5, 5000, "t2_reach_fault", steps);
    chk("t2_timeout_len", 32'(steps), 32'd4096);
    chk("t2_fault_en", 32'(en), 32'd0);
    chk("t2_fault_o", 32'(fault), 32'd1);
    repeat (3) step();
    req = 1'b0;
    step();
    chk("t2_off_state", 32'(state), 32'd0);
    chk("t2_off_fault", 32'(fault), 32'd0);
    req = 1'b1;
    step();
    chk("t2_restart", 32'(state), 32'd1);

    // Trim loading in OFF, STARTUP and READY
    req = 1'b0;
    step();
    cfgBias = 4'h3; cfgCurv = 5'h1F; cfgVbg = 5'h00; trimLoad = 1'b1;
    step();
    trimLoad = 1'b0;
    chk("t4_off_load", 32'({trimBias, trimCurv, trimVbg}), 32'({4'h3, 5'h1F, 5'h00}));
    req = 1'b1;
    repeat (2) step();
    cfgBias = 4'hA; cfgCurv = 5'h05; cfgVbg = 5'h0A; trimLoad = 1'b1;
    step();
    trimLoad = 1'b0;
    chk("t4_startup_ignored", 32'({trimBias, trimCurv, trimVbg}), 32'({4'h3, 5'h1F, 5'h00}));
    bgValidN = 1'b0;
    runUntil(3'd4, 400, "t4_reach_ready", steps);
    cfgBias = 4'h5; cfgCurv = 5'h0A; cfgVbg = 5'h15; trimLoad = 1'b1;
    step();
    trimLoad = 1'b0;
    chk("t4_ready_load", 32'({trimBias, trimCurv, trimVbg}), 32'({4'h5, 5'h0A, 5'h15}));
    chk("t4_requal_state", 32'(state), 32'd2);
    chk("t4_requal_ready_o", 32'(ready), 32'd0);
    runUntil(3'd4, 400, "t4_ready_again", steps);
    chk("t4_requal_len", 32'(steps), 32'd257);

    // Request drop mid-STARTUP and mid-SETTLE
    req = 1'b0;
    step();
    req = 1'b1;
    repeat (11) step();
    req = 1'b0;
    step();
    chk("t5_drop_startup", 32'({state, en, bgStartup}), 32'({3'd0, 1'b0, 1'b0}));
    req = 1'b1;
    runUntil(3'd2, 200, "t5_reach_settle", steps);
    repeat (20) step();
    req = 1'b0;
    step();
    chk("t5_drop_settle", 32'({state, en, bgStartup}), 32'({3'd0, 1'b0, 1'b0}));

    // Asynchronous reset while READY, checked between clock edges
    req = 1'b1;
    vbiasReq = 1'b1;
    runUntil(3'd4, 400, "t5_reach_ready", steps);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_async_reset", 32'(obsVec()), 32'(RST_VEC));
    modelReset();
    #1;
    rst = 1'b0;

    // Random traffic against the model
    req = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (req) begin
        if ($urandom_range(199) == 0) req = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        req = 1'b1;
      end
      if ($urandom_range(9) == 0) bgValidN = ~bgValidN;
      vbiasReq = ($urandom_range(3) != 0);
      trimLoad = ($urandom_range(49) == 0);
      cfgBias = 4'($urandom);
      cfgCurv = 5'($urandom);
      cfgVbg = 5'($urandom);
      step();
    end
    trimLoad = 1'b0;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
